am2940_counter_core: RTL and testbench

Register and counter core of the AM2940 DMA address generator slice. It holds the control register, the address register/counter and the word register/counter, and executes the 3-bit instruction stream. Each cycle it updates the counters and produces DONE. It sits directly upstream of the output-data 3:1 multiplexer and supplies that multiplexer's three sources and its select.

---
 rtl/am2940_counter_core_pkg.sv | 27 ++
 rtl/am2940_counter_core_counter8.sv | 30 +++
 rtl/am2940_counter_core.sv | 144 ++++++++++++++
 tb/tb_am2940_counter_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/am2940_counter_core_pkg.sv
// Shared types for the AM2940 register/counter core: instruction and mode
// encodings plus the read-mux select codes.
package am2940_pkg;

  typedef enum logic [2:0] {
    I_WRCR   = 3'd0,
    I_RDCR   = 3'd1,
    I_RDWC   = 3'd2,
    I_RDAC   = 3'd3,
    I_REINIT = 3'd4,
    I_LDADDR = 3'd5,
    I_LDWC   = 3'd6,
    I_ENCNT  = 3'd7
  } am2940_instr_e;

  typedef enum logic [1:0] {
    M_CNT_DN   = 2'd0,
    M_CNT_UP   = 2'd1,
    M_ADDR_CMP = 2'd2,
    M_FREE_RUN = 2'd3
  } am2940_mode_e;

  localparam logic [1:0] SEL_AC = 2'b00;
  localparam logic [1:0] SEL_WC = 2'b01;
  localparam logic [1:0] SEL_CR = 2'b10;

endpackage

// File: rtl/am2940_counter_core_counter8.sv
// 8-bit up/down counter with load, hold, enable and terminal-count carry-out.
// Load has priority over counting; hold freezes the count but not a load.
module am2940_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_ld_val,
  input  logic       i_hold,
  input  logic       i_en,
  input  logic       i_dn,
  output logic [7:0] o_q,
  output logic       o_co
);

  logic [7:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 8'h00;
    end else if (i_load) begin
      r_q <= i_ld_val;
    end else if (i_en && !i_hold) begin
      r_q <= i_dn ? (r_q - 8'd1) : (r_q + 8'd1);
    end
  end

  assign o_q  = r_q;
  assign o_co = i_dn ? (r_q == 8'h00) : (r_q == 8'hFF);

endmodule

// File: rtl/am2940_counter_core.sv
// AM2940 control/address/word register core with instruction decode and DONE.
// Define AM2940_CASCADE_EN to add the aci/wci carry-in and aco/wco carry-out ports.
module am2940_counter_core
  import am2940_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] instr,
  input  logic [7:0] din,
`ifdef AM2940_CASCADE_EN
  input  logic       aci,
  input  logic       wci,
  output logic       aco,
  output logic       wco,
`endif
  output logic [7:0] ac_q,
  output logic [7:0] wc_q,
  output logic [2:0] cr_q,
  output logic [1:0] rd_sel,
  output logic       rd_en,
  output logic       done
);

  am2940_instr_e w_op;
  am2940_mode_e  w_mode;
  logic          w_dir_dn;

  logic [2:0] r_cr;
  logic [7:0] r_ar;
  logic [7:0] r_wr;

  logic [7:0] w_ac;
  logic [7:0] w_wc;
  logic       w_ac_co;
  logic       w_wc_co;
  logic       w_aci;
  logic       w_wci;

  logic       w_ac_load;
  logic [7:0] w_ac_ld_val;
  logic       w_wc_load;
  logic [7:0] w_wc_ld_val;
  logic       w_cnt;
  logic       w_wc_moves;

  assign w_op     = am2940_instr_e'(instr);
  assign w_mode   = am2940_mode_e'(r_cr[1:0]);
  assign w_dir_dn = r_cr[2];

`ifdef AM2940_CASCADE_EN
  assign w_aci = aci;
  assign w_wci = wci;
`else
  assign w_aci = 1'b1;
  assign w_wci = 1'b1;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    rd_sel = SEL_AC;
    rd_en  = 1'b0;
    case (w_op)
      I_RDCR:  begin rd_sel = SEL_CR; rd_en = 1'b1; end
      I_RDWC:  begin rd_sel = SEL_WC; rd_en = 1'b1; end
      I_RDAC:  begin rd_sel = SEL_AC; rd_en = 1'b1; end
      default: begin rd_sel = SEL_AC; rd_en = 1'b0; end
    endcase
  end

  always_comb begin
    done = 1'b0;
    case (w_mode)
      M_CNT_DN:   done = (w_wc == 8'h01);
      M_CNT_UP:   done = (w_wc == r_wr);
      M_ADDR_CMP: done = (w_ac == r_wr);
      M_FREE_RUN: done = 1'b0;
      default:    done = 1'b0;
    endcase
  end

  // Mode 1 counts the word counter up from zero toward WR, so loads clear it.
  assign w_ac_load   = (w_op == I_LDADDR) || (w_op == I_REINIT);
  assign w_ac_ld_val = (w_op == I_LDADDR) ? din : r_ar;
  assign w_wc_load   = (w_op == I_LDWC) || (w_op == I_REINIT);
  assign w_wc_ld_val = (w_mode == M_CNT_UP) ? 8'h00 :
                       (w_op == I_LDWC)     ? din   : r_wr;
  assign w_cnt       = (w_op == I_ENCNT);
  assign w_wc_moves  = (w_mode != M_ADDR_CMP);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (rst) begin
      r_cr <= 3'b000;
      r_ar <= 8'h00;
      r_wr <= 8'h00;
    end else begin
      case (w_op)
        I_WRCR:   r_cr <= din[2:0];
        I_LDADDR: r_ar <= din;
        I_LDWC:   r_wr <= din;
        default:  ;
      endcase
    end
  end

  am2940_counter8 u_ac (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_ac_load),
    .i_ld_val (w_ac_ld_val),
    .i_hold   (done),
    .i_en     (w_cnt && w_aci),
    .i_dn     (w_dir_dn),
    .o_q      (w_ac),
    .o_co     (w_ac_co)
  );

  am2940_counter8 u_wc (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_wc_load),
    .i_ld_val (w_wc_ld_val),
    .i_hold   (done),
    .i_en     (w_cnt && w_wci && w_wc_moves),
    .i_dn     (w_mode != M_CNT_UP),
    .o_q      (w_wc),
    .o_co     (w_wc_co)
  );

`ifdef AM2940_CASCADE_EN
  // Carry-out reports that an enabled, unfrozen step would wrap the counter.
  assign aco = w_ac_co && w_aci && !done;
  assign wco = w_wc_co && w_wci && w_wc_moves && !done;
`else
  logic w_unused_co;
  assign w_unused_co = w_ac_co ^ w_wc_co;
`endif

  assign ac_q = w_ac;
  assign wc_q = w_wc;
  assign cr_q = r_cr;

endmodule

// File: tb/tb_am2940_counter_core.sv
// Directed, table-driven bench for am2940_counter_core, plus hand-written
// reset and cascade sequences.
module tb_am2940_counter_core;
  import am2940_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] instr;
  logic [7:0] din;
  logic [7:0] ac_q;
  logic [7:0] wc_q;
  logic [2:0] cr_q;
  logic [1:0] rd_sel;
  logic       rd_en;
  logic       done;
`ifdef AM2940_CASCADE_EN
  logic       aci;
  logic       wci;
  logic       aco;
  logic       wco;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] instr;
    logic [7:0] din;
    logic [7:0] ac;
    logic [7:0] wc;
    logic [2:0] cr;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  am2940_counter_core dut (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .din    (din),
`ifdef AM2940_CASCADE_EN
    .aci    (aci),
    .wci    (wci),
    .aco    (aco),
    .wco    (wco),
`endif
    .ac_q   (ac_q),
    .wc_q   (wc_q),
    .cr_q   (cr_q),
    .rd_sel (rd_sel),
    .rd_en  (rd_en),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] i, input logic [7:0] d, input logic [7:0] ac,
                     input logic [7:0] wc, input logic [2:0] cr, input logic dn);
    vec_t v;
    v.instr = i; v.din = d; v.ac = ac; v.wc = wc; v.cr = cr; v.done = dn;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] exp_sel(input logic [2:0] i);
    case (i)
      3'd1:    return 2'b10;
      3'd2:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    instr = v.instr;
    din   = v.din;
    #1;
    check($sformatf("v%0d rd_sel", idx), {30'd0, rd_sel}, {30'd0, exp_sel(v.instr)});
    check($sformatf("v%0d rd_en", idx), {31'd0, rd_en},
          {31'd0, (v.instr >= 3'd1 && v.instr <= 3'd3)});
    @(posedge clk);
    #1;
    check($sformatf("v%0d ac", idx), {24'd0, ac_q}, {24'd0, v.ac});
    check($sformatf("v%0d wc", idx), {24'd0, wc_q}, {24'd0, v.wc});
    check($sformatf("v%0d cr", idx), {29'd0, cr_q}, {29'd0, v.cr});
    check($sformatf("v%0d done", idx), {31'd0, done}, {31'd0, v.done});
  endtask

  task automatic check_state(input string tag, input logic [7:0] ac, input logic [7:0] wc,
                             input logic [2:0] cr, input logic dn);
    check({tag, " ac"}, {24'd0, ac_q}, {24'd0, ac});
    check({tag, " wc"}, {24'd0, wc_q}, {24'd0, wc});
    check({tag, " cr"}, {29'd0, cr_q}, {29'd0, cr});
    check({tag, " done"}, {31'd0, done}, {31'd0, dn});
  endtask

  initial begin
    // Mode 0 countdown, reads, REINIT after done.
    add(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    add(3'd5, 8'h10, 8'h10, 8'h00, 3'd0, 1'b0);
    add(3'd6, 8'h03, 8'h10, 8'h03, 3'd0, 1'b0);
    add(3'd7, 8'h00, 8'h11, 8'h02, 3'd0, 1'b0);
    add(3'd7, 8'h00, 8'h12, 8'h01, 3'd0, 1'b1);
    add(3'd7, 8'h00, 8'h12, 8'h01, 3'd0, 1'b1);
    add(3'd1, 8'hAA, 8'h12, 8'h01, 3'd0, 1'b1);
    add(3'd2, 8'hAA, 8'h12, 8'h01, 3'd0, 1'b1);
    add(3'd3, 8'hAA, 8'h12, 8'h01, 3'd0, 1'b1);
    add(3'd4, 8'h00, 8'h10, 8'h03, 3'd0, 1'b0);
    // Mode 1, address decrement with wrap.
    add(3'd0, 8'h05, 8'h10, 8'h03, 3'd5, 1'b1);
    add(3'd5, 8'h00, 8'h00, 8'h03, 3'd5, 1'b1);
    add(3'd6, 8'h02, 8'h00, 8'h00, 3'd5, 1'b0);
    add(3'd7, 8'h00, 8'hFF, 8'h01, 3'd5, 1'b0);
    add(3'd7, 8'h00, 8'hFE, 8'h02, 3'd5, 1'b1);
    add(3'd7, 8'h00, 8'hFE, 8'h02, 3'd5, 1'b1);
    // Mode 2 address compare.
    add(3'd0, 8'h02, 8'hFE, 8'h02, 3'd2, 1'b0);
    add(3'd6, 8'h05, 8'hFE, 8'h05, 3'd2, 1'b0);
    add(3'd5, 8'h03, 8'h03, 8'h05, 3'd2, 1'b0);
    add(3'd7, 8'h00, 8'h04, 8'h05, 3'd2, 1'b0);
    add(3'd7, 8'h00, 8'h05, 8'h05, 3'd2, 1'b1);
    add(3'd7, 8'h00, 8'h05, 8'h05, 3'd2, 1'b1);
    // Mode 3: AC FF->00, WC 00->FF, done never set.
    add(3'd0, 8'h03, 8'h05, 8'h05, 3'd3, 1'b0);
    add(3'd5, 8'hFF, 8'hFF, 8'h05, 3'd3, 1'b0);
    add(3'd6, 8'h00, 8'hFF, 8'h00, 3'd3, 1'b0);
    add(3'd7, 8'h00, 8'h00, 8'hFF, 3'd3, 1'b0);
    add(3'd7, 8'h00, 8'h01, 8'hFE, 3'd3, 1'b0);
    // REINIT in mode 1 clears WC; WR=00 so done rises.
    add(3'd0, 8'h01, 8'h01, 8'hFE, 3'd1, 1'b0);
    add(3'd4, 8'h00, 8'hFF, 8'h00, 3'd1, 1'b1);

    rst   = 1'b0;
    instr = 3'd3;
    din   = 8'h00;
`ifdef AM2940_CASCADE_EN
    aci = 1'b1;
    wci = 1'b1;
`endif
    #1 rst = 1'b1;
    #1;
    check_state("reset", 8'h00, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], k);

`ifdef AM2940_CASCADE_EN
    begin
      vec_t v;
      v.instr = 3'd0; v.din = 8'h03; v.ac = 8'hFF; v.wc = 8'h00; v.cr = 3'd3; v.done = 1'b0;
      run_vec(v, 100);
      check("casc aco at FF", {31'd0, aco}, 32'd1);
      check("casc wco at 00", {31'd0, wco}, 32'd1);
      v.instr = 3'd7; v.din = 8'h00; v.ac = 8'h00; v.wc = 8'hFF;
      run_vec(v, 101);
      check("casc aco at 00", {31'd0, aco}, 32'd0);
      @(negedge clk);
      aci = 1'b0;
      wci = 1'b0;
      run_vec(v, 102);
      aci = 1'b1;
      wci = 1'b1;
    end
`endif

    // Mid-cycle async reset: takes effect without a clock edge.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_state("async rst", 8'h00, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset held across an ENCNT edge: no partial update; then normal execution.
    begin
      vec_t v;
      v.instr = 3'd5; v.din = 8'h20; v.ac = 8'h20; v.wc = 8'h00; v.cr = 3'd0; v.done = 1'b0;
      run_vec(v, 200);
      v.instr = 3'd6; v.din = 8'h05; v.wc = 8'h05;
      run_vec(v, 201);
    end
    @(negedge clk);
    instr = 3'd7;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("rst over edge", 8'h00, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("first after rst", 8'h01, 8'hFF, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
